// File: rtl/mem_line_adapter.sv
// Line-to-beat adapter: turns one full-line read/write request into a MIF command
// plus DATA_CYCLES data beats, and reassembles read beats into a line response.
module mem_line_adapter #(
  parameter int ADDR_BITS   = 26,
  parameter int TAG_BITS    = 5,
  parameter int DATA_BITS   = 128,
  parameter int DATA_CYCLES = 4
) (
  input  logic                             clk,
  input  logic                             reset,

  input  logic                             line_req_valid,
  output logic                             line_req_ready,
  input  logic                             line_req_rw,
  input  logic [ADDR_BITS-1:0]             line_req_addr,
  input  logic [TAG_BITS-1:0]              line_req_tag,
  input  logic [DATA_BITS*DATA_CYCLES-1:0] line_req_data,

  output logic                             line_resp_valid,
  input  logic                             line_resp_ready,
  output logic [DATA_BITS*DATA_CYCLES-1:0] line_resp_data,
  output logic [TAG_BITS-1:0]              line_resp_tag,

  output logic                             mem_req_valid,
  input  logic                             mem_req_ready,
  output logic                             mem_req_rw,
  output logic [ADDR_BITS-1:0]             mem_req_addr,
  output logic [TAG_BITS-1:0]              mem_req_tag,

  output logic                             mem_req_data_valid,
  input  logic                             mem_req_data_ready,
  output logic [DATA_BITS-1:0]             mem_req_data_bits,

  input  logic                             mem_resp_valid,
  input  logic [DATA_BITS-1:0]             mem_resp_data,
  input  logic [TAG_BITS-1:0]              mem_resp_tag,

  output logic                             tag_error
);

  localparam int LINE_BITS = DATA_BITS * DATA_CYCLES;
  localparam int BEAT_W    = (DATA_CYCLES > 1) ? $clog2(DATA_CYCLES) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(DATA_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_WDATA, S_RDATA, S_RESP} state_t;

  state_t                 state_q, state_d;
  logic [BEAT_W-1:0]      beat_q, beat_d;
  logic                   tag_error_q, tag_error_d;
  logic                   rw_q, rw_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [TAG_BITS-1:0]    tag_q, tag_d;
  logic [LINE_BITS-1:0]   line_q, line_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      beat_q      <= '0;
      tag_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      tag_error_q <= tag_error_d;
    end
  end

  // Payload registers only carry data qualified by state, so they skip reset.
  always_ff @(posedge clk) begin
    rw_q   <= rw_d;
    addr_q <= addr_d;
    tag_q  <= tag_d;
    line_q <= line_d;
  end

  always_comb begin
    state_d            = state_q;
    beat_d             = beat_q;
    tag_error_d        = tag_error_q;
    rw_d               = rw_q;
    addr_d             = addr_q;
    tag_d              = tag_q;
    line_d             = line_q;
    line_req_ready     = 1'b0;
    mem_req_valid      = 1'b0;
    mem_req_data_valid = 1'b0;
    line_resp_valid    = 1'b0;

    case (state_q)
      S_IDLE: begin
        line_req_ready = 1'b1;
        if (line_req_valid) begin
          rw_d    = line_req_rw;
          addr_d  = line_req_addr;
          tag_d   = line_req_tag;
          line_d  = line_req_data;
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          beat_d  = '0;
          state_d = rw_q ? S_WDATA : S_RDATA;
        end
      end
      S_WDATA: begin
        mem_req_data_valid = 1'b1;
        if (mem_req_data_ready) begin
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == LAST_BEAT) state_d = S_IDLE;
        end
      end
      S_RDATA: begin
        if (mem_resp_valid) begin
          for (int unsigned i = 0; i < DATA_CYCLES; i++) begin
            if (beat_q == BEAT_W'(i)) line_d[i*DATA_BITS +: DATA_BITS] = mem_resp_data;
          end
          if (mem_resp_tag != tag_q) tag_error_d = 1'b1;
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == LAST_BEAT) state_d = S_RESP;
        end
      end
      S_RESP: begin
        line_resp_valid = 1'b1;
        if (line_resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (mem_resp_valid && (state_q != S_RDATA)) tag_error_d = 1'b1;
  end

  always_comb begin
    mem_req_data_bits = '0;
    for (int unsigned i = 0; i < DATA_CYCLES; i++) begin
      if (beat_q == BEAT_W'(i)) mem_req_data_bits = line_q[i*DATA_BITS +: DATA_BITS];
    end
  end

  assign mem_req_rw     = rw_q;
  assign mem_req_addr   = addr_q;
  assign mem_req_tag    = tag_q;
  assign line_resp_data = line_q;
  assign line_resp_tag  = tag_q;
  assign tag_error      = tag_error_q;

endmodule

// File: tb/tb_mem_line_adapter.sv
// Self-checking bench for mem_line_adapter: directed scenarios plus randomized
// read/write lines compared against a transaction-level expectation.
module tb_mem_line_adapter;

  localparam int AW = 26;
  localparam int TW = 5;
  localparam int DW = 128;
  localparam int NC = 4;
  localparam int LW = DW * NC;

  logic          clk = 1'b0;
  logic          reset;
  logic          line_req_valid, line_req_ready, line_req_rw;
  logic [AW-1:0] line_req_addr;
  logic [TW-1:0] line_req_tag;
  logic [LW-1:0] line_req_data;
  logic          line_resp_valid, line_resp_ready;
  logic [LW-1:0] line_resp_data;
  logic [TW-1:0] line_resp_tag;
  logic          mem_req_valid, mem_req_ready, mem_req_rw;
  logic [AW-1:0] mem_req_addr;
  logic [TW-1:0] mem_req_tag;
  logic          mem_req_data_valid, mem_req_data_ready;
  logic [DW-1:0] mem_req_data_bits;
  logic          mem_resp_valid;
  logic [DW-1:0] mem_resp_data;
  logic [TW-1:0] mem_resp_tag;
  logic          tag_error;

  int passed = 0;
  int total  = 0;
  logic exp_err = 1'b0;

  mem_line_adapter #(.ADDR_BITS(AW), .TAG_BITS(TW), .DATA_BITS(DW), .DATA_CYCLES(NC)) dut (
    .clk(clk), .reset(reset),
    .line_req_valid(line_req_valid), .line_req_ready(line_req_ready),
    .line_req_rw(line_req_rw), .line_req_addr(line_req_addr),
    .line_req_tag(line_req_tag), .line_req_data(line_req_data),
    .line_resp_valid(line_resp_valid), .line_resp_ready(line_resp_ready),
    .line_resp_data(line_resp_data), .line_resp_tag(line_resp_tag),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
    .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits(mem_req_data_bits),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_tag(mem_resp_tag),
    .tag_error(tag_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1ns after posedge.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("valid_exclusive", LW'(mem_req_valid) + LW'(mem_req_data_valid) + LW'(line_resp_valid) <= 1, 1);
  endtask

  function automatic logic [DW-1:0] rnd_beat();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] l;
    for (int i = 0; i < NC; i++) l[i*DW +: DW] = rnd_beat();
    return l;
  endfunction

  task automatic issue_req(input logic rw, input logic [AW-1:0] a, input logic [TW-1:0] t,
                           input logic [LW-1:0] line);
    chk("req_ready_idle", line_req_ready, 1);
    line_req_valid = 1'b1; line_req_rw = rw; line_req_addr = a; line_req_tag = t; line_req_data = line;
    tick();
    line_req_valid = 1'b0; line_req_addr = '1; line_req_tag = '1; line_req_data = rnd_line();
  endtask

  task automatic cmd_phase(input logic rw, input logic [AW-1:0] a, input logic [TW-1:0] t,
                           input int hold);
    for (int i = 0; i <= hold; i++) begin
      chk("cmd_valid", mem_req_valid, 1);
      chk("cmd_rw", mem_req_rw, rw);
      chk("cmd_addr", mem_req_addr, a);
      chk("cmd_tag", mem_req_tag, t);
      chk("cmd_no_data", mem_req_data_valid, 0);
      chk("cmd_req_ready", line_req_ready, 0);
      mem_req_ready = (i == hold);
      tick();
    end
    mem_req_ready = 1'b0;
  endtask

  task automatic send_wbeats(input logic [LW-1:0] line, input int nbeats, input int maxgap);
    for (int b = 0; b < nbeats; b++) begin
      int gap = $urandom_range(0, maxgap);
      for (int g = 0; g <= gap; g++) begin
        chk("wbeat_valid", mem_req_data_valid, 1);
        chk("wbeat_bits", mem_req_data_bits, line[b*DW +: DW]);
        chk("wbeat_no_resp", line_resp_valid, 0);
        mem_req_data_ready = (g == gap);
        tick();
      end
      mem_req_data_ready = 1'b0;
    end
  endtask

  task automatic write_line(input logic [AW-1:0] a, input logic [TW-1:0] t, input logic [LW-1:0] line,
                            input int hold, input int maxgap);
    issue_req(1'b1, a, t, line);
    cmd_phase(1'b1, a, t, hold);
    send_wbeats(line, NC, maxgap);
    chk("wr_done_ready", line_req_ready, 1);
    chk("wr_no_resp", line_resp_valid, 0);
    chk("wr_tag_error", tag_error, exp_err);
  endtask

  task automatic read_line(input logic [AW-1:0] a, input logic [TW-1:0] t, input logic [LW-1:0] line,
                           input int bad_beat, input logic [TW-1:0] bad_tag,
                           input int maxgap, input int cmd_hold, input int resp_hold);
    issue_req(1'b0, a, t, 'x);
    cmd_phase(1'b0, a, t, cmd_hold);
    for (int b = 0; b < NC; b++) begin
      int gap = $urandom_range(0, maxgap);
      for (int g = 0; g < gap; g++) begin
        chk("rd_gap_no_resp", line_resp_valid, 0);
        chk("rd_gap_no_cmd", mem_req_valid, 0);
        tick();
      end
      mem_resp_valid = 1'b1;
      mem_resp_data  = line[b*DW +: DW];
      mem_resp_tag   = (b == bad_beat) ? bad_tag : t;
      if (mem_resp_tag != t) exp_err = 1'b1;
      tick();
      mem_resp_valid = 1'b0; mem_resp_data = rnd_beat();
      chk("rd_tag_error", tag_error, exp_err);
      if (b < NC - 1) chk("rd_early_resp", line_resp_valid, 0);
    end
    for (int i = 0; i <= resp_hold; i++) begin
      chk("resp_valid", line_resp_valid, 1);
      chk("resp_data", line_resp_data, line);
      chk("resp_tag", line_resp_tag, t);
      chk("resp_req_ready", line_req_ready, 0);
      line_resp_ready = (i == resp_hold);
      tick();
    end
    line_resp_ready = 1'b0;
    chk("rd_done_ready", line_req_ready, 1);
    chk("rd_resp_dropped", line_resp_valid, 0);
  endtask

  initial begin
    logic [LW-1:0] l;
    reset = 1'b0;
    line_req_valid = 0; line_req_rw = 0; line_req_addr = '0; line_req_tag = '0; line_req_data = '0;
    line_resp_ready = 0; mem_req_ready = 0; mem_req_data_ready = 0;
    mem_resp_valid = 0; mem_resp_data = '0; mem_resp_tag = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_data_valid", mem_req_data_valid, 0);
    chk("rst_resp_valid", line_resp_valid, 0);
    chk("rst_tag_error", tag_error, 0);
    @(negedge clk) reset = 1'b1;
    tick();
    chk("rst_req_ready", line_req_ready, 1);

    // Plain write with ready held high: beats A0..A3 on consecutive cycles.
    l = {128'hA3, 128'hA2, 128'hA1, 128'hA0};
    write_line(26'h10, 5'd3, l, 0, 0);

    // Read with gapped beats, then a response held off for 5 cycles.
    l = {128'hB3, 128'hB2, 128'hB1, 128'hB0};
    read_line(26'h20, 5'd7, l, -1, '0, 3, 0, 0);
    read_line(26'h24, 5'd7, rnd_line(), -1, '0, 1, 0, 5);

    // Command stalled 3 cycles; fields must stay put and no beats appear.
    write_line(26'h30, 5'd1, rnd_line(), 3, 2);

    // Stray response beat while idle is dropped and flagged.
    mem_resp_valid = 1'b1; mem_resp_data = rnd_beat(); mem_resp_tag = 5'd9;
    tick();
    mem_resp_valid = 1'b0;
    exp_err = 1'b1;
    chk("stray_tag_error", tag_error, 1);
    chk("stray_no_resp", line_resp_valid, 0);
    chk("stray_idle", line_req_ready, 1);

    // Reset mid-write after the second beat, then tag_error is cleared.
    l = rnd_line();
    issue_req(1'b1, 26'h40, 5'd2, l);
    cmd_phase(1'b1, 26'h40, 5'd2, 0);
    send_wbeats(l, 2, 0);
    #2 reset = 1'b0;
    #1;
    chk("abort_mem_req_valid", mem_req_valid, 0);
    chk("abort_data_valid", mem_req_data_valid, 0);
    chk("abort_resp_valid", line_resp_valid, 0);
    chk("abort_tag_error", tag_error, 0);
    exp_err = 1'b0;
    @(negedge clk) reset = 1'b1;
    tick();
    chk("abort_req_ready", line_req_ready, 1);
    chk("abort_stays_quiet", mem_req_data_valid, 0);
    write_line(26'h44, 5'd4, rnd_line(), 0, 0);

    // Mismatched tag on beat 2: line still completes, error is sticky.
    read_line(26'h20, 5'd7, rnd_line(), 2, 5'd6, 1, 0, 0);
    chk("sticky_after_mismatch", tag_error, 1);
    write_line(26'h50, 5'd7, rnd_line(), 0, 0);
    chk("sticky_later", tag_error, 1);

    // Clear the flag and run a randomized mix.
    reset = 1'b0;
    #1 exp_err = 1'b0;
    @(negedge clk) reset = 1'b1;
    tick();
    for (int n = 0; n < 24; n++) begin
      logic [AW-1:0] a = AW'($urandom);
      logic [TW-1:0] t = TW'($urandom);
      if ($urandom_range(0, 1) == 1)
        write_line(a, t, rnd_line(), $urandom_range(0, 3), 3);
      else
        read_line(a, t, rnd_line(), ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, NC - 1)) : -1,
                  t ^ TW'(1), 3, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed", passed, total);
    $fatal(1, "timeout");
  end

endmodule
